// File: rtl/mul_issue_scheduler.sv
// Round-robin issue of MUL reservation stations into a shared fixed-latency
// multiplier, with tag tracking, a credit-limited result FIFO and CDB drain.
module mul_issue_scheduler #(
  parameter int NUM_RS    = 3,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 4,
  parameter int LAT       = 4,
  parameter int BUF_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [NUM_RS-1:0]          rs_req,
  input  logic [NUM_RS*DATA_W-1:0]   rs_a,
  input  logic [NUM_RS*DATA_W-1:0]   rs_b,
  input  logic [NUM_RS*TAG_W-1:0]    rs_tag,
  output logic [NUM_RS-1:0]          rs_gnt,
  output logic [DATA_W-1:0]          mul_a,
  output logic [DATA_W-1:0]          mul_b,
  input  logic [2*DATA_W-1:0]        mul_p,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [2*DATA_W-1:0]        cdb_data,
  input  logic                       cdb_ack,
  output logic                       busy
);

  localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int BP_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CR_W  = $clog2(BUF_DEPTH + 1);
  localparam int P_W   = 2 * DATA_W;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
  } trk_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [P_W-1:0]   prod;
  } res_t;

  function automatic logic [PTR_W-1:0] rs_wrap(
    input logic [PTR_W-1:0] p,
    input int               k
  );
    int s;
    s = int'(p) + k;
    if (s >= NUM_RS) s = s - NUM_RS;
    return PTR_W'(s);
  endfunction

  function automatic logic [BP_W-1:0] bp_inc(
    input logic [BP_W-1:0] p
  );
    return (int'(p) == BUF_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              can_issue;
  logic [CR_W-1:0]   credits;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [TAG_W-1:0]  sel_tag;
  trk_t              trk [LAT];
  res_t              rbuf [BUF_DEPTH];
  logic [BP_W-1:0]   wr_ptr;
  logic [BP_W-1:0]   rd_ptr;
  logic [CR_W-1:0]   count;
  logic              wr_en;
  logic              pop;

  // A credit stands for one free buffer slot not yet promised to an op.
  assign can_issue = !reset && !flush && (credits != '0);

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    rs_gnt  = '0;
    if (can_issue) begin
      for (int k = 0; k < NUM_RS; k++) begin
        if (!gnt_any && rs_req[rs_wrap(rr_ptr, k)]) begin
          gnt_any = 1'b1;
          gnt_idx = rs_wrap(rr_ptr, k);
        end
      end
    end
    if (gnt_any) rs_gnt[gnt_idx] = 1'b1;
  end

  assign sel_a   = rs_a[int'(gnt_idx)*DATA_W +: DATA_W];
  assign sel_b   = rs_b[int'(gnt_idx)*DATA_W +: DATA_W];
  assign sel_tag = rs_tag[int'(gnt_idx)*TAG_W +: TAG_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      mul_a  <= '0;
      mul_b  <= '0;
    end else if (gnt_any) begin
      rr_ptr <= rs_wrap(gnt_idx, 1);
      mul_a  <= sel_a;
      mul_b  <= sel_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < LAT; i++) trk[i] <= '0;
    end else begin
      trk[0].vld <= gnt_any;
      trk[0].tag <= sel_tag;
      for (int i = 1; i < LAT; i++) trk[i] <= trk[i-1];
    end
  end

  assign wr_en = trk[LAT-1].vld;
  assign pop   = cdb_valid && cdb_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) rbuf[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        rbuf[wr_ptr].tag  <= trk[LAT-1].tag;
        rbuf[wr_ptr].prod <= mul_p;
        wr_ptr            <= bp_inc(wr_ptr);
      end
      if (pop) rd_ptr <= bp_inc(rd_ptr);
      count <= count + CR_W'(wr_en) - CR_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      credits <= CR_W'(BUF_DEPTH);
    end else begin
      credits <= credits - CR_W'(gnt_any) + CR_W'(pop);
    end
  end

  assign cdb_valid = (count != '0);
  assign cdb_tag   = rbuf[rd_ptr].tag;
  assign cdb_data  = rbuf[rd_ptr].prod;
  assign busy      = (credits != CR_W'(BUF_DEPTH));

  a_gnt_onehot: assert property (
    @(posedge clk) $onehot0(rs_gnt)
  );

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset || flush)
    !(wr_en && !pop && count == CR_W'(BUF_DEPTH))
  );

  a_credit_max: assert property (
    @(posedge clk) disable iff (reset)
    credits <= CR_W'(BUF_DEPTH)
  );

endmodule
